// File: rtl/eng_controller.sv
// Sequencing FSM for the exponential-series datapath: start edge detect, load/init,
// the MULX/MULC/ACC loop until counter carry-out, and a watchdog pass limit.
module eng_controller #(
  parameter int unsigned MAX_ITER = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic co,
  output logic zx,
  output logic initx,
  output logic ldx,
  output logic zt,
  output logic initt,
  output logic ldt,
  output logic zr,
  output logic initr,
  output logic ldr,
  output logic zc,
  output logic ldc,
  output logic enc,
  output logic s,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MULX = 3'd2,
    MULC = 3'd3,
    ACC  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [7:0] MAX8 = 8'(MAX_ITER);

  state_t     state, state_nx;
  logic       start_q;
  logic [7:0] iter;
  logic [7:0] iter_inc;
  logic       err_q;
  logic       start_rise;
  logic       wd_hit;

  assign start_rise = start & ~start_q;
  assign iter_inc   = iter + 8'd1;
  assign wd_hit     = (iter_inc == MAX8);

  // Clear/init-x strobes are reserved for a future clear command.
  assign zx    = 1'b0;
  assign zt    = 1'b0;
  assign zr    = 1'b0;
  assign zc    = 1'b0;
  assign initx = 1'b0;
  assign err   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      start_q <= 1'b0;
      iter    <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      start_q <= start;
      case (state)
        LOAD: begin
          iter  <= '0;
          err_q <= 1'b0;
        end
        ACC: begin
          iter <= iter_inc;
          // Carry-out wins over the watchdog in the same pass.
          if (!co && wd_hit) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    ldx      = 1'b0;
    initt    = 1'b0;
    ldt      = 1'b0;
    initr    = 1'b0;
    ldr      = 1'b0;
    ldc      = 1'b0;
    enc      = 1'b0;
    s        = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise) state_nx = LOAD;
      end
      LOAD: begin
        ldx      = 1'b1;
        initt    = 1'b1;
        initr    = 1'b1;
        ldc      = 1'b1;
        busy     = 1'b1;
        state_nx = MULX;
      end
      MULX: begin
        ldt      = 1'b1;
        busy     = 1'b1;
        state_nx = MULC;
      end
      MULC: begin
        s        = 1'b1;
        ldt      = 1'b1;
        busy     = 1'b1;
        state_nx = ACC;
      end
      ACC: begin
        ldr      = 1'b1;
        enc      = 1'b1;
        busy     = 1'b1;
        state_nx = (co || wd_hit) ? DONE : MULX;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
